// File: rtl/nbout_psum_ctrl.sv
// nbout_psum_ctrl: NBout buffer plus sequencer that seeds, accumulates, drains and writes back one partial-sum entry.
module nbout_psum_ctrl #(
   parameter int BIT_WIDTH  = 16,
   parameter int Tn         = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int ITER_WIDTH = 8,
   parameter int NFU_LAT    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   output logic                    o_ready,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [ITER_WIDTH-1:0]   i_num_iters,
   input  logic                    i_init_zero,
   output logic [Tn*BIT_WIDTH-1:0] o_partial_sum,
   output logic                    o_load_partial_sum,
   output logic                    o_nfu1_req,
   input  logic [Tn*BIT_WIDTH-1:0] i_nfu_output,
   output logic                    o_done,
   input  logic                    i_wr_en,
   input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
   input  logic [Tn*BIT_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
   output logic [Tn*BIT_WIDTH-1:0] o_rd_data
);
   localparam int W     = Tn * BIT_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int DW    = $clog2(NFU_LAT + 2);
   typedef enum logic [2:0] {IDLE, LOAD, ACCUM, DRAIN, WB} state_t;
   state_t state, state_nx;
   logic [W-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ITER_WIDTH-1:0] cnt;
   logic [DW-1:0] dcnt;
   logic accept, load_nx, req_nx, done_nx;
   logic [W-1:0] seed;
   assign accept = i_start && o_ready;
   // a fill write landing in the accept cycle is forwarded so LOAD sees the new data
   assign seed = i_init_zero ? '0 : (i_wr_en && i_wr_addr == i_addr) ? i_wr_data : mem[i_addr];
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? LOAD : IDLE;
         LOAD:    state_nx = (cnt != '0) ? ACCUM : (NFU_LAT > 0) ? DRAIN : WB;
         ACCUM:   state_nx = (cnt != ITER_WIDTH'(1)) ? ACCUM : (NFU_LAT > 0) ? DRAIN : WB;
         DRAIN:   state_nx = (dcnt == DW'(1)) ? WB : DRAIN;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      o_ready = state == IDLE;
      load_nx = state_nx == LOAD;
      req_nx  = state_nx == ACCUM;
      done_nx = state_nx == WB;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         o_load_partial_sum <= 1'b0;
         o_nfu1_req         <= 1'b0;
         o_done             <= 1'b0;
         o_partial_sum      <= '0;
         o_rd_data          <= '0;
         addr_q             <= '0;
         cnt                <= '0;
         dcnt               <= '0;
      end else begin
         o_load_partial_sum <= load_nx;
         o_nfu1_req         <= req_nx;
         o_done             <= done_nx;
         o_rd_data          <= mem[i_rd_addr];
         dcnt               <= (state == DRAIN) ? dcnt - DW'(1) : DW'(NFU_LAT);
         if (accept) begin
            addr_q        <= i_addr;
            cnt           <= i_num_iters;
            o_partial_sum <= seed;
         end else if (state == ACCUM) begin
            cnt <= cnt - ITER_WIDTH'(1);
         end
      end
   end
   // the array survives reset; only an uninterrupted WB cycle commits the sum
   always_ff @(posedge clk) begin
      if (state == WB && !rst) mem[addr_q] <= i_nfu_output;
      else if (i_wr_en && state == IDLE) mem[i_wr_addr] <= i_wr_data;
   end
endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// tb_nbout_psum_ctrl: random and directed commands against a lane-wise arithmetic model of NBout.
module tb_nbout_psum_ctrl;
   localparam int BW = 16, TN = 16, AW = 4, IW = 8, LAT = 2, W = TN * BW;
   logic clk = 1'b0, rst, i_start, o_ready, i_init_zero, o_load_partial_sum, o_nfu1_req, o_done, i_wr_en;
   logic [AW-1:0] i_addr, i_wr_addr, i_rd_addr;
   logic [IW-1:0] i_num_iters;
   logic [W-1:0] o_partial_sum, i_nfu_output, i_wr_data, o_rd_data;
   logic [W-1:0] acc, p1, p2;
   logic [W-1:0] ref_mem [16];
   int vectors = 0, errors = 0;
   always #5 clk = ~clk;
   nbout_psum_ctrl #(.BIT_WIDTH(BW), .Tn(TN), .ADDR_WIDTH(AW), .ITER_WIDTH(IW), .NFU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready), .i_addr(i_addr),
      .i_num_iters(i_num_iters), .i_init_zero(i_init_zero), .o_partial_sum(o_partial_sum),
      .o_load_partial_sum(o_load_partial_sum), .o_nfu1_req(o_nfu1_req), .i_nfu_output(i_nfu_output),
      .o_done(o_done), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data)
   );
   function automatic logic [W-1:0] add_lanes(input logic [W-1:0] v, input int k);
      logic [W-1:0] r;
      for (int i = 0; i < TN; i++) r[i*BW +: BW] = v[i*BW +: BW] + BW'(k);
      return r;
   endfunction
   function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
      return {TN{v}};
   endfunction
   function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction
   // NFU-2 stand-in: load seeds, each request adds 1 per lane, result visible LAT cycles later
   always_ff @(posedge clk) begin
      if (o_load_partial_sum) acc <= o_partial_sum;
      else if (o_nfu1_req) acc <= add_lanes(acc, 1);
      p1 <= acc;
      p2 <= p1;
   end
   assign i_nfu_output = p2;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic fill(input int a, input logic [W-1:0] d);
      i_wr_en = 1'b1; i_wr_addr = AW'(a); i_wr_data = d;
      step();
      i_wr_en = 1'b0;
      ref_mem[a] = d;
   endtask
   task automatic rd_chk(input int a);
      i_rd_addr = AW'(a);
      step();
      chk("rd_data", o_rd_data, ref_mem[a]);
   endtask
   task automatic run_cmd(input int a, input int n, input bit iz, input bit hold, input bit wr_same,
                          input bit mid_wr, input logic [W-1:0] wd);
      int lat;
      logic [W-1:0] seed;
      lat = 1 + n + LAT + 1;
      chk("ready_idle", W'(o_ready), W'(1'b1));
      i_start = 1'b1; i_addr = AW'(a); i_num_iters = IW'(n); i_init_zero = iz;
      if (wr_same) begin
         i_wr_en = 1'b1; i_wr_addr = AW'(a); i_wr_data = wd;
         ref_mem[a] = wd;
      end
      seed = iz ? '0 : ref_mem[a];
      step();
      i_wr_en = 1'b0;
      if (!hold) i_start = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         if (mid_wr && k == 2) begin
            i_wr_en = 1'b1; i_wr_addr = AW'(3); i_wr_data = rnd();
         end else i_wr_en = 1'b0;
         chk("load", W'(o_load_partial_sum), W'(k == 1));
         chk("nfu1_req", W'(o_nfu1_req), W'(k >= 2 && k <= n + 1));
         chk("done", W'(o_done), W'(k == lat));
         chk("ready_busy", W'(o_ready), W'(1'b0));
         if (k == 1 || k == lat) chk("psum", o_partial_sum, seed);
         if (k == lat) i_start = 1'b0;
         step();
      end
      i_wr_en = 1'b0;
      ref_mem[a] = add_lanes(seed, n);
      chk("ready_back", W'(o_ready), W'(1'b1));
      chk("done_once", W'(o_done), W'(1'b0));
   endtask
   initial begin
      int a;
      logic [W-1:0] seed7;
      rst = 1'b1; i_start = 1'b0; i_addr = '0; i_num_iters = '0; i_init_zero = 1'b0;
      i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_rd_addr = '0;
      step(); step();
      chk("rst_ready", W'(o_ready), W'(1'b1));
      chk("rst_load", W'(o_load_partial_sum), W'(1'b0));
      chk("rst_req", W'(o_nfu1_req), W'(1'b0));
      chk("rst_done", W'(o_done), W'(1'b0));
      chk("rst_psum", o_partial_sum, '0);
      chk("rst_rd", o_rd_data, '0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) fill(i, rnd());
      fill(3, rep(16'h0010));
      run_cmd(3, 4, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      i_rd_addr = AW'(3); step();
      chk("nb3_0014", o_rd_data, rep(16'h0014));
      run_cmd(5, 0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      i_rd_addr = AW'(5); step();
      chk("nb5_zero", o_rd_data, '0);
      run_cmd(6, 3, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      rd_chk(6);
      run_cmd(8, 4, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      rd_chk(3);
      rd_chk(8);
      run_cmd(3, 2, 1'b0, 1'b0, 1'b1, 1'b0, rep(16'h00AA));
      rd_chk(3);
      seed7 = ref_mem[7];
      i_start = 1'b1; i_addr = AW'(7); i_num_iters = IW'(5); i_init_zero = 1'b0;
      step();
      i_start = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ready", W'(o_ready), W'(1'b1));
      chk("abort_load", W'(o_load_partial_sum), W'(1'b0));
      chk("abort_req", W'(o_nfu1_req), W'(1'b0));
      chk("abort_done", W'(o_done), W'(1'b0));
      chk("abort_psum", o_partial_sum, '0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("abort_no_done", W'(o_done), W'(1'b0));
      end
      i_rd_addr = AW'(7); step();
      chk("abort_nb7", o_rd_data, seed7);
      run_cmd(9, 255, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      rd_chk(9);
      for (int t = 0; t < 25; t++) begin
         if ($urandom_range(0, 1) == 1) fill($urandom_range(0, 15), rnd());
         a = $urandom_range(0, 15);
         run_cmd(a, $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), (a != 3) && ($urandom_range(0, 1) == 1), rnd());
         rd_chk(a);
         rd_chk($urandom_range(0, 15));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
